// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm -- RC4 key-scheduling phase 2 controller.
// For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
// Each iteration issues four S-memory transactions in order R(i), R(j), W(i), W(j).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          begin a full 256-iteration schedule (sampled in IDLE only)
//   secret_key     key, byte 0 is the MSB byte; stable from start until finish
//   finish         one-cycle pulse once all 256 swaps are written
//   busy           high from the cycle after start is accepted until finish
//   mem_start      one-cycle request pulse to the S-memory interface
//   mem_readWrite  0 = read, 1 = write; held until mem_finish
//   mem_adr        S address; held until mem_finish
//   mem_wdata      write data; held until mem_finish
//   mem_finish     memory done pulse
//   mem_rdata      read data, valid while mem_finish is high
module ksa_swap_fsm #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   finish,
  output logic                   busy,
  output logic                   mem_start,
  output logic                   mem_readWrite,
  output logic [7:0]             mem_adr,
  output logic [7:0]             mem_wdata,
  input  logic                   mem_finish,
  input  logic [7:0]             mem_rdata
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    RD_I_W,
    CALC_J,
    RD_J,
    RD_J_W,
    WR_I,
    WR_I_W,
    WR_J,
    WR_J_W,
    NEXT,
    DONE
  } state_t;

  state_t        state;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [KW-1:0] kidx;
  logic [7:0]    key_byte;

  // Key byte select; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KW'(k)) key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

  // Requests are registered, so mem_start is high during the first cycle of
  // each *_W state and is cleared by the default assignment one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      si            <= '0;
      sj            <= '0;
      kidx          <= '0;
      finish        <= 1'b0;
      busy          <= 1'b0;
      mem_start     <= 1'b0;
      mem_readWrite <= 1'b0;
      mem_adr       <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_start <= 1'b0;
      finish    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            busy  <= 1'b1;
            state <= RD_I;
          end
        end
        RD_I: begin
          mem_start     <= 1'b1;
          mem_readWrite <= 1'b0;
          mem_adr       <= i;
          state         <= RD_I_W;
        end
        RD_I_W: begin
          if (mem_finish) begin
            si    <= mem_rdata;
            state <= CALC_J;
          end
        end
        CALC_J: begin
          j     <= j + si + key_byte;
          state <= RD_J;
        end
        RD_J: begin
          mem_start     <= 1'b1;
          mem_readWrite <= 1'b0;
          mem_adr       <= j;
          state         <= RD_J_W;
        end
        RD_J_W: begin
          if (mem_finish) begin
            sj    <= mem_rdata;
            state <= WR_I;
          end
        end
        WR_I: begin
          mem_start     <= 1'b1;
          mem_readWrite <= 1'b1;
          mem_adr       <= i;
          mem_wdata     <= sj;
          state         <= WR_I_W;
        end
        WR_I_W: begin
          if (mem_finish) state <= WR_J;
        end
        WR_J: begin
          mem_start     <= 1'b1;
          mem_readWrite <= 1'b1;
          mem_adr       <= j;
          mem_wdata     <= si;
          state         <= WR_J_W;
        end
        WR_J_W: begin
          if (mem_finish) state <= NEXT;
        end
        NEXT: begin
          if (i == 8'hFF) begin
            finish <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            i     <= i + 8'd1;
            kidx  <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + KW'(1);
            state <= RD_I;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
